ctrl_resolve_stage: RTL and testbench

CTRL_RESOLVE_STAGE -- requirements
Module: ctrl_resolve_stage

---
 rtl/ctrl_resolve_stage.sv | 128 ++++++++++++
 tb/tb_ctrl_resolve_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_resolve_stage.sv
// Control-instruction resolve stage: link writeback, predictor update,
// fetch redirect handshake with post-redirect recovery drain.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush_i               squash all block state (priority over all)
//   valid_i, pc_i, result_i, nextPC_i, direction_i, flags_i, tag_i
//                         control-ALU packet (flags: 0 misp, 4 link, 5 xfer)
//   stall_o               hold upstream packet (state != IDLE)
//   wbValid_o/wbTag_o/wbData_o                      link writeback
//   bpUpdValid_o/bpUpdPC_o/bpUpdTarget_o/bpUpdDir_o predictor update
//   redirectValid_o/redirectPC_o, redirectReady_i   fetch redirect
//   mispCount_o           saturating count of accepted redirects
module ctrl_resolve_stage #(
  parameter int TAG_W          = 7,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      result_i,
  input  logic [31:0]      nextPC_i,
  input  logic             direction_i,
  input  logic [7:0]       flags_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             stall_o,
  output logic             wbValid_o,
  output logic [TAG_W-1:0] wbTag_o,
  output logic [31:0]      wbData_o,
  output logic             bpUpdValid_o,
  output logic [31:0]      bpUpdPC_o,
  output logic [31:0]      bpUpdTarget_o,
  output logic             bpUpdDir_o,
  output logic             redirectValid_o,
  output logic [31:0]      redirectPC_o,
  input  logic             redirectReady_i,
  output logic [15:0]      mispCount_o
);

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] REDIRECT_WAIT = 2'd1;
  localparam logic [1:0] RECOVER       = 2'd2;

  // Loaded on entry so RECOVER spans exactly RECOVER_CYCLES cycles.
  localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  recover_cnt;
  logic [15:0] misp_count;
  logic        accept;
  logic        do_wb;
  logic        do_bp;
  logic        unused_flags;

  assign stall_o      = (state != IDLE);
  assign accept       = valid_i && !stall_o && !flush_i;
  assign do_wb        = accept && flags_i[4];
  assign do_bp        = accept && flags_i[5];
  assign mispCount_o  = misp_count;
  assign unused_flags = ^{flags_i[7:6], flags_i[3:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      recover_cnt     <= 4'd0;
      misp_count      <= 16'd0;
      wbValid_o       <= 1'b0;
      wbTag_o         <= '0;
      wbData_o        <= 32'd0;
      bpUpdValid_o    <= 1'b0;
      bpUpdPC_o       <= 32'd0;
      bpUpdTarget_o   <= 32'd0;
      bpUpdDir_o      <= 1'b0;
      redirectValid_o <= 1'b0;
      redirectPC_o    <= 32'd0;
    end else if (flush_i) begin
      state           <= IDLE;
      recover_cnt     <= 4'd0;
      wbValid_o       <= 1'b0;
      bpUpdValid_o    <= 1'b0;
      redirectValid_o <= 1'b0;
    end else begin
      wbValid_o    <= do_wb;
      bpUpdValid_o <= do_bp;
      if (do_wb) begin
        wbTag_o  <= tag_i;
        wbData_o <= result_i;
      end
      if (do_bp) begin
        bpUpdPC_o     <= pc_i;
        bpUpdTarget_o <= nextPC_i;
        bpUpdDir_o    <= direction_i;
      end
      case (state)
        IDLE: begin
          if (accept && flags_i[0]) begin
            state           <= REDIRECT_WAIT;
            redirectValid_o <= 1'b1;
            redirectPC_o    <= nextPC_i;
          end
        end
        REDIRECT_WAIT: begin
          if (redirectReady_i) begin
            state           <= RECOVER;
            redirectValid_o <= 1'b0;
            recover_cnt     <= RECOVER_LAST;
            if (misp_count != 16'hFFFF)
              misp_count <= misp_count + 16'd1;
          end
        end
        RECOVER: begin
          if (recover_cnt == 4'd0)
            state <= IDLE;
          else
            recover_cnt <= recover_cnt - 4'd1;
        end
        default: begin
          state           <= IDLE;
          recover_cnt     <= 4'd0;
          redirectValid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_resolve_stage.sv
// Self-checking bench for ctrl_resolve_stage.
// Scoreboard of expected per-packet outputs, one task per scenario.
module tb_ctrl_resolve_stage;

  localparam int TAG_W = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic             valid_i;
  logic [31:0]      pc_i;
  logic [31:0]      result_i;
  logic [31:0]      nextPC_i;
  logic             direction_i;
  logic [7:0]       flags_i;
  logic [TAG_W-1:0] tag_i;
  logic             stall_o;
  logic             wbValid_o;
  logic [TAG_W-1:0] wbTag_o;
  logic [31:0]      wbData_o;
  logic             bpUpdValid_o;
  logic [31:0]      bpUpdPC_o;
  logic [31:0]      bpUpdTarget_o;
  logic             bpUpdDir_o;
  logic             redirectValid_o;
  logic [31:0]      redirectPC_o;
  logic             redirectReady_i;
  logic [15:0]      mispCount_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_misp;

  typedef struct {
    logic             wb_v;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             bp_v;
    logic [31:0]      pc;
    logic [31:0]      tgt;
    logic             dir;
    logic             rv;
    logic [31:0]      rpc;
  } exp_t;

  exp_t sb[$];

  ctrl_resolve_stage #(.TAG_W(TAG_W), .RECOVER_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .result_i(result_i), .nextPC_i(nextPC_i),
    .direction_i(direction_i), .flags_i(flags_i), .tag_i(tag_i),
    .stall_o(stall_o), .wbValid_o(wbValid_o), .wbTag_o(wbTag_o),
    .wbData_o(wbData_o), .bpUpdValid_o(bpUpdValid_o),
    .bpUpdPC_o(bpUpdPC_o), .bpUpdTarget_o(bpUpdTarget_o),
    .bpUpdDir_o(bpUpdDir_o), .redirectValid_o(redirectValid_o),
    .redirectPC_o(redirectPC_o), .redirectReady_i(redirectReady_i),
    .mispCount_o(mispCount_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [7:0] f, input logic [31:0] pc,
                         input logic [31:0] res, input logic [31:0] npc,
                         input logic dir, input logic [TAG_W-1:0] tag);
    valid_i     = 1'b1;
    flags_i     = f;
    pc_i        = pc;
    result_i    = res;
    nextPC_i    = npc;
    direction_i = dir;
    tag_i       = tag;
  endtask

  task automatic push_exp();
    exp_t e;
    e.wb_v = flags_i[4];
    e.tag  = tag_i;
    e.data = result_i;
    e.bp_v = flags_i[5];
    e.pc   = pc_i;
    e.tgt  = nextPC_i;
    e.dir  = direction_i;
    e.rv   = flags_i[0];
    e.rpc  = nextPC_i;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] f, input logic [31:0] pc,
                       input logic [31:0] res, input logic [31:0] npc,
                       input logic dir, input logic [TAG_W-1:0] tag);
    set_pkt(f, pc, res, npc, dir, tag);
    push_exp();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0; valid_i = 1'b0; redirectReady_i = 1'b0;
    flags_i = 8'd0; pc_i = '0; result_i = '0; nextPC_i = '0;
    direction_i = 1'b0; tag_i = '0;
    tick(); tick();
    reset = 1'b0;
    exp_misp = 16'd0;
    n_chk++;
    if ({stall_o, wbValid_o, bpUpdValid_o, redirectValid_o} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 0000",
               {stall_o, wbValid_o, bpUpdValid_o, redirectValid_o});
    end
    n_chk++;
    if ({wbTag_o, wbData_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o,
         redirectPC_o, mispCount_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got wd=%h bp=%h rp=%h mc=%h want 0",
               wbData_o, bpUpdPC_o, redirectPC_o, mispCount_o);
    end
  endtask

  task automatic test_jal();
    exp_t e;
    drive(8'hB4, 32'h400, 32'h408, 32'h800, 1'b1, 7'd5);
    tick();
    valid_i = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({wbValid_o, wbTag_o, wbData_o} !== {e.wb_v, e.tag, e.data}) begin
      n_fail++;
      $display("FAIL jal_wb got %b/%h/%h want %b/%h/%h", wbValid_o,
               wbTag_o, wbData_o, e.wb_v, e.tag, e.data);
    end
    n_chk++;
    if ({bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o} !==
        {e.bp_v, e.pc, e.tgt, e.dir}) begin
      n_fail++;
      $display("FAIL jal_bp got %b/%h/%h/%b want %b/%h/%h/%b",
               bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o,
               e.bp_v, e.pc, e.tgt, e.dir);
    end
    n_chk++;
    if ({redirectValid_o, stall_o} !== {e.rv, 1'b0}) begin
      n_fail++;
      $display("FAIL jal_redir got rv=%b st=%b want rv=%b st=0",
               redirectValid_o, stall_o, e.rv);
    end
    tick();
    n_chk++;
    if ({wbValid_o, bpUpdValid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL jal_pulse got %b want 00", {wbValid_o, bpUpdValid_o});
    end
  endtask

  task automatic test_mispredict();
    exp_t e;
    redirectReady_i = 1'b0;
    drive(8'hA5, 32'h500, 32'h0, 32'h520, 1'b1, 7'd3);
    tick();
    valid_i = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({wbValid_o, bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o} !==
        {e.wb_v, e.bp_v, e.pc, e.tgt, e.dir}) begin
      n_fail++;
      $display("FAIL misp_bp got %b%b/%h/%h want %b%b/%h/%h", wbValid_o,
               bpUpdValid_o, bpUpdPC_o, bpUpdTarget_o, e.wb_v, e.bp_v,
               e.pc, e.tgt);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_chk++;
      if ({redirectValid_o, redirectPC_o, stall_o} !== {e.rv, e.rpc, 1'b1})
      begin
        n_fail++;
        $display("FAIL misp_hold%0d got %b/%h/%b want %b/%h/1", i,
                 redirectValid_o, redirectPC_o, stall_o, e.rv, e.rpc);
      end
    end
    redirectReady_i = 1'b1;
    tick();
    redirectReady_i = 1'b0;
    exp_misp = exp_misp + 16'd1;
    n_chk++;
    if ({redirectValid_o, stall_o, mispCount_o} !== {2'b01, exp_misp}) begin
      n_fail++;
      $display("FAIL misp_accept got rv=%b st=%b mc=%h want rv=0 st=1 mc=%h",
               redirectValid_o, stall_o, mispCount_o, exp_misp);
    end
    tick();
    n_chk++;
    if (stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL misp_recover2 got st=%b want 1", stall_o);
    end
    tick();
    n_chk++;
    if ({stall_o, redirectValid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL misp_idle got st/rv=%b want 00",
               {stall_o, redirectValid_o});
    end
  endtask

  task automatic test_stall_hold();
    exp_t e;
    int   waited;
    redirectReady_i = 1'b1;
    drive(8'hA5, 32'h600, 32'h0, 32'h640, 1'b0, 7'd4);
    tick();
    e = sb.pop_front();
    n_chk++;
    if ({redirectValid_o, redirectPC_o} !== {e.rv, e.rpc}) begin
      n_fail++;
      $display("FAIL hold_redir got %b/%h want %b/%h", redirectValid_o,
               redirectPC_o, e.rv, e.rpc);
    end
    exp_misp = exp_misp + 16'd1;
    set_pkt(8'h94, 32'h610, 32'h1234, 32'h614, 1'b0, 7'd9);
    waited = 0;
    while (stall_o === 1'b1 && waited < 10) begin
      tick();
      waited++;
      n_chk++;
      if ({wbValid_o, bpUpdValid_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_nopulse%0d got %b want 00", waited,
                 {wbValid_o, bpUpdValid_o});
      end
    end
    n_chk++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_timeout got st=%b want 0", stall_o);
    end
    push_exp();
    tick();
    valid_i = 1'b0;
    redirectReady_i = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({wbValid_o, wbTag_o, wbData_o, bpUpdValid_o} !==
        {e.wb_v, e.tag, e.data, e.bp_v}) begin
      n_fail++;
      $display("FAIL hold_accept got %b/%h/%h/%b want %b/%h/%h/%b",
               wbValid_o, wbTag_o, wbData_o, bpUpdValid_o,
               e.wb_v, e.tag, e.data, e.bp_v);
    end
    tick();
    n_chk++;
    if ({wbValid_o, mispCount_o} !== {1'b0, exp_misp}) begin
      n_fail++;
      $display("FAIL hold_once got wb=%b mc=%h want wb=0 mc=%h",
               wbValid_o, mispCount_o, exp_misp);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      redirectReady_i = 1'b0;
      drive(8'hA1, 32'h700, 32'h0, 32'h740 + 32'(k), 1'b1, 7'd1);
      tick();
      valid_i = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if ({redirectValid_o, redirectPC_o} !== {e.rv, e.rpc}) begin
        n_fail++;
        $display("FAIL flush_pre%0d got %b/%h want %b/%h", k,
                 redirectValid_o, redirectPC_o, e.rv, e.rpc);
      end
      flush_i = 1'b1;
      redirectReady_i = (k == 1);
      tick();
      flush_i = 1'b0;
      redirectReady_i = 1'b0;
      n_chk++;
      if ({redirectValid_o, stall_o, mispCount_o} !== {2'b00, exp_misp})
      begin
        n_fail++;
        $display("FAIL flush_rw%0d got rv=%b st=%b mc=%h want 0/0/%h", k,
                 redirectValid_o, stall_o, mispCount_o, exp_misp);
      end
    end
    set_pkt(8'hB5, 32'h780, 32'h788, 32'h7C0, 1'b1, 7'd2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    n_chk++;
    if ({wbValid_o, bpUpdValid_o, redirectValid_o, stall_o} !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_drop got %b want 0000",
               {wbValid_o, bpUpdValid_o, redirectValid_o, stall_o});
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    dut.misp_count = 16'hFFFE;
    exp_misp = 16'hFFFE;
    redirectReady_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, 32'h900, 32'h0, 32'h940, 1'b1, 7'd6);
      tick();
      valid_i = 1'b0;
      e = sb.pop_front();
      n_chk++;
      if ({redirectValid_o, redirectPC_o} !== {e.rv, e.rpc}) begin
        n_fail++;
        $display("FAIL sat_redir%0d got %b/%h want %b/%h", k,
                 redirectValid_o, redirectPC_o, e.rv, e.rpc);
      end
      tick();
      if (exp_misp != 16'hFFFF) exp_misp = exp_misp + 16'd1;
      n_chk++;
      if (mispCount_o !== exp_misp) begin
        n_fail++;
        $display("FAIL sat_count%0d got %h want %h", k, mispCount_o,
                 exp_misp);
      end
      tick(); tick();
    end
    redirectReady_i = 1'b0;
  endtask

  task automatic test_reset_recover();
    exp_t e;
    redirectReady_i = 1'b1;
    drive(8'hA5, 32'hA00, 32'h0, 32'hA40, 1'b1, 7'd8);
    tick();
    valid_i = 1'b0;
    e = sb.pop_front();
    tick();
    redirectReady_i = 1'b0;
    n_chk++;
    if ({stall_o, redirectValid_o} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rr_inrecover got st/rv=%b want 10",
               {stall_o, redirectValid_o});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_misp = 16'd0;
    n_chk++;
    if ({stall_o, wbValid_o, bpUpdValid_o, redirectValid_o, wbTag_o,
         wbData_o, bpUpdPC_o, bpUpdTarget_o, bpUpdDir_o, redirectPC_o,
         mispCount_o} !== '0) begin
      n_fail++;
      $display("FAIL rr_zero got st=%b bp=%h rp=%h mc=%h want 0", stall_o,
               bpUpdPC_o, redirectPC_o, mispCount_o);
    end
    drive(8'hB4, 32'hB00, 32'hB08, 32'hC00, 1'b1, 7'd11);
    tick();
    valid_i = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({wbValid_o, wbTag_o, wbData_o, bpUpdValid_o, bpUpdPC_o} !==
        {e.wb_v, e.tag, e.data, e.bp_v, e.pc}) begin
      n_fail++;
      $display("FAIL rr_first got %b/%h/%h/%b/%h want %b/%h/%h/%b/%h",
               wbValid_o, wbTag_o, wbData_o, bpUpdValid_o, bpUpdPC_o,
               e.wb_v, e.tag, e.data, e.bp_v, e.pc);
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_mispredict();
    test_stall_hold();
    test_flush();
    test_saturate();
    test_reset_recover();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
